// File: rtl/phase_frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// phase_pkg
//   Shared types and helpers for the phase frame sequencer.
//   - phase_word_t  : one phase-bus word {channel ID, phase value}
//   - frame_state_t : frame parser states
//   - PHASE_SYNC_DEFAULT : default frame start marker
//   - count_ok / chan_ok : range checks on COUNT and channel bytes
// -----------------------------------------------------------------------------
package phase_pkg;

   localparam logic [7:0] PHASE_SYNC_DEFAULT = 8'hA5;

   typedef struct packed {
      logic [7:0] chan;
      logic [7:0] phase;
   } phase_word_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNT_ST = 2'd1,
      CHAN     = 2'd2,
      PHASE    = 2'd3
   } frame_state_t;

   // A frame must carry between 1 and num_channels pairs.
   function automatic logic count_ok(input logic [7:0] count, input int num_channels);
      return (count != 8'd0) && (int'(count) <= num_channels);
   endfunction

   // Channel IDs 0..num_channels-1 address a real phase register.
   function automatic logic chan_ok(input logic [7:0] chan, input int num_channels);
      return int'(chan) < num_channels;
   endfunction

endpackage

// File: rtl/phase_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_frame_sequencer_if
//   Byte-stream input and phase-bus output of the phase frame sequencer.
//   rx_valid/rx_byte  : received byte strobe and data (from the byte receiver)
//   phase_data        : [15:8] channel ID, [7:0] phase value (broadcast)
//   phase_en          : one-cycle write strobe qualifying phase_data
//   frame_done        : one-cycle pulse, frame completed without errors
//   frame_err         : one-cycle pulse, frame aborted or contained errors
//   busy              : frame in progress
//   modport slave  : the sequencer itself
//   modport master : the surrounding logic (receiver + phase registers)
// -----------------------------------------------------------------------------
interface phase_frame_sequencer_if;

   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [15:0] phase_data;
   logic        phase_en;
   logic        frame_done;
   logic        frame_err;
   logic        busy;

   modport slave (
      input  rx_valid, rx_byte,
      output phase_data, phase_en, frame_done, frame_err, busy
   );

   modport master (
      output rx_valid, rx_byte,
      input  phase_data, phase_en, frame_done, frame_err, busy
   );

endinterface

// File: rtl/phase_frame_sequencer_byte_timeout.sv
// -----------------------------------------------------------------------------
// byte_timeout
//   Saturating inter-byte timer for the frame parser.
//   clk, rst : clock, synchronous active-high reset
//   enable   : count while high (frame in progress); held at zero otherwise
//   kick     : a byte was accepted this cycle; restarts the count
//   expired  : the edge at the end of this cycle is the TIMEOUT_CYCLES-th idle
//              edge since the last byte; never asserted together with kick
// -----------------------------------------------------------------------------
module byte_timeout #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst || kick || !enable) begin
         count <= '0;
      end else if (count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   // Firing one edge early in combinational form lets the parser register its
   // abort on the very edge that completes TIMEOUT_CYCLES idle cycles. A byte
   // on that same edge wins, so kick masks the expiry.
   assign expired = enable && !kick && (count >= LAST);

endmodule

// File: rtl/phase_frame_sequencer.sv
// -----------------------------------------------------------------------------
// phase_frame_sequencer
//   Parses host frames {SYNC_BYTE, COUNT, COUNT x (channel, phase)} from a
//   byte stream and issues channel-addressed writes on the shared phase bus.
//   Invalid channels are skipped and flag the frame; stalled frames are
//   aborted by an inter-byte timeout.
//   clk  : system clock
//   rst  : synchronous active-high reset; abandons any frame silently
//   bus  : phase_frame_sequencer_if.slave (rx_valid, rx_byte in; phase_data,
//          phase_en, frame_done, frame_err, busy out)
//   All outputs except busy are registered; busy is decoded from the state
//   register.
// -----------------------------------------------------------------------------
module phase_frame_sequencer
   import phase_pkg::*;
#(
   parameter int         NUM_CHANNELS   = 64,
   parameter logic [7:0] SYNC_BYTE      = PHASE_SYNC_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   phase_frame_sequencer_if.slave  bus
);

   frame_state_t state, state_next;
   logic [7:0]   remaining, remaining_next;
   logic [7:0]   chan_reg, chan_next;
   logic         err_flag, err_next;
   phase_word_t  word_q, word_next;
   logic         en_q, en_next;
   logic         done_q, done_next;
   logic         ferr_q, ferr_next;
   logic         timeout_expired;
   logic         chan_bad;

   byte_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .enable  (state != IDLE),
      .kick    (bus.rx_valid),
      .expired (timeout_expired)
   );

   assign chan_bad = !chan_ok(chan_reg, NUM_CHANNELS);

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      state_next     = state;
      remaining_next = remaining;
      chan_next      = chan_reg;
      err_next       = err_flag;
      word_next      = word_q;
      en_next        = 1'b0;
      done_next      = 1'b0;
      ferr_next      = 1'b0;

      if (bus.rx_valid) begin
         unique case (state)
            IDLE: begin
               // Anything but the marker is line noise between frames.
               if (bus.rx_byte == SYNC_BYTE) state_next = COUNT_ST;
            end
            COUNT_ST: begin
               if (!count_ok(bus.rx_byte, NUM_CHANNELS)) begin
                  ferr_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  remaining_next = bus.rx_byte;
                  err_next       = 1'b0;
                  state_next     = CHAN;
               end
            end
            CHAN: begin
               chan_next  = bus.rx_byte;
               state_next = PHASE;
            end
            PHASE: begin
               remaining_next = remaining - 8'd1;
               if (chan_bad) begin
                  err_next = 1'b1;
               end else begin
                  word_next = '{chan: chan_reg, phase: bus.rx_byte};
                  en_next   = 1'b1;
               end
               if (remaining == 8'd1) begin
                  // The last pair's own channel check counts toward the verdict.
                  state_next = IDLE;
                  if (err_flag || chan_bad) ferr_next = 1'b1;
                  else                      done_next = 1'b1;
               end else begin
                  state_next = CHAN;
               end
            end
            default: state_next = IDLE;
         endcase
      end else if (timeout_expired) begin
         ferr_next  = 1'b1;
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= 8'd0;
         chan_reg  <= 8'd0;
         err_flag  <= 1'b0;
         word_q    <= '0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         chan_reg  <= chan_next;
         err_flag  <= err_next;
         word_q    <= word_next;
         en_q      <= en_next;
         done_q    <= done_next;
         ferr_q    <= ferr_next;
      end
   end

   assign bus.phase_data = word_q;
   assign bus.phase_en   = en_q;
   assign bus.frame_done = done_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_phase_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_frame_sequencer
//   Directed bench. dut_a uses NUM_CHANNELS=64, dut_b NUM_CHANNELS=255; both
//   use TIMEOUT_CYCLES=16. Inputs change on the falling edge; each cyc() call
//   waits for a falling edge, so outputs observed right after cyc() reflect
//   the byte driven by the previous cyc() call.
// -----------------------------------------------------------------------------
module tb_phase_frame_sequencer;

   logic       clk;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       sel_b;

   int checks = 0;
   int errors = 0;
   int n_en   = 0;
   int n_done = 0;
   int n_err  = 0;
   int n_both = 0;
   int en0, done0, err0;

   phase_frame_sequencer_if bus_a ();
   phase_frame_sequencer_if bus_b ();

   assign bus_a.rx_valid = rx_valid & ~sel_b;
   assign bus_a.rx_byte  = rx_byte;
   assign bus_b.rx_valid = rx_valid & sel_b;
   assign bus_b.rx_byte  = rx_byte;

   phase_frame_sequencer #(
      .NUM_CHANNELS   (64),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   phase_frame_sequencer #(
      .NUM_CHANNELS   (255),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse tallies for dut_a, sampled just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (bus_a.phase_en)   n_en++;
      if (bus_a.frame_done) n_done++;
      if (bus_a.frame_err)  n_err++;
      if (bus_a.frame_done && bus_a.frame_err) n_both++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] b);
      @(negedge clk);
      rx_valid = v;
      rx_byte  = b;
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      sel_b    = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check16("rst_data", bus_a.phase_data, 16'h0000);
      check1("rst_en",    bus_a.phase_en,   1'b0);
      check1("rst_done",  bus_a.frame_done, 1'b0);
      check1("rst_err",   bus_a.frame_err,  1'b0);
      check1("rst_busy",  bus_a.busy,       1'b0);
      rst = 1'b0;

      // Nominal frame, back-to-back bytes
      cyc(1, 8'hA5); cyc(1, 8'h02); cyc(1, 8'h03); cyc(1, 8'h40);
      check1("nom_busy", bus_a.busy, 1'b1);
      cyc(1, 8'h07);
      check1("nom_en1",      bus_a.phase_en,   1'b1);
      check16("nom_data1",   bus_a.phase_data, 16'h0340);
      check1("nom_done_mid", bus_a.frame_done, 1'b0);
      cyc(1, 8'hFF);
      check1("nom_gap_en", bus_a.phase_en, 1'b0);
      cyc(0, 8'h00);
      check1("nom_en2",    bus_a.phase_en,   1'b1);
      check16("nom_data2", bus_a.phase_data, 16'h07FF);
      check1("nom_done",   bus_a.frame_done, 1'b1);
      check1("nom_err",    bus_a.frame_err,  1'b0);
      check1("nom_idle",   bus_a.busy,       1'b0);

      // Invalid channel 0x50 inside a two-pair frame
      cyc(1, 8'hA5); cyc(1, 8'h02); cyc(1, 8'h50); cyc(1, 8'h11);
      cyc(1, 8'h05);
      check1("badch_no_write", bus_a.phase_en, 1'b0);
      cyc(1, 8'h22);
      cyc(0, 8'h00);
      check1("badch_en",    bus_a.phase_en,   1'b1);
      check16("badch_data", bus_a.phase_data, 16'h0522);
      check1("badch_err",   bus_a.frame_err,  1'b1);
      check1("badch_done",  bus_a.frame_done, 1'b0);
      cyc(0, 8'h00);
      check1("hold_en",    bus_a.phase_en,   1'b0);
      check16("hold_data", bus_a.phase_data, 16'h0522);
      check1("hold_err",   bus_a.frame_err,  1'b0);

      // Bad count, then a good single-pair frame
      cyc(1, 8'hA5); cyc(1, 8'h00);
      cyc(0, 8'h00);
      check1("cnt0_err",  bus_a.frame_err, 1'b1);
      check1("cnt0_en",   bus_a.phase_en,  1'b0);
      check1("cnt0_busy", bus_a.busy,      1'b0);
      cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'h01); cyc(1, 8'h10);
      cyc(0, 8'h00);
      check1("cnt1_en",    bus_a.phase_en,   1'b1);
      check16("cnt1_data", bus_a.phase_data, 16'h0110);
      check1("cnt1_done",  bus_a.frame_done, 1'b1);

      // Timer restart: byte 15 cycles after the last one, then a byte on the
      // 16th cycle, which must win over the expiry on that same edge.
      cyc(1, 8'hA5); cyc(1, 8'h02); cyc(1, 8'h02);
      repeat (14) cyc(0, 8'h00);
      cyc(1, 8'h33);
      check1("t15_err",  bus_a.frame_err, 1'b0);
      check1("t15_busy", bus_a.busy,      1'b1);
      cyc(0, 8'h00);
      check1("t15_en",    bus_a.phase_en,   1'b1);
      check16("t15_data", bus_a.phase_data, 16'h0233);
      check1("t15_done",  bus_a.frame_done, 1'b0);
      repeat (14) cyc(0, 8'h00);
      cyc(1, 8'h04);
      check1("t16_pre_err", bus_a.frame_err, 1'b0);
      cyc(1, 8'h55);
      check1("t16_err",  bus_a.frame_err, 1'b0);
      check1("t16_busy", bus_a.busy,      1'b1);
      cyc(0, 8'h00);
      check1("t16_en",    bus_a.phase_en,   1'b1);
      check16("t16_data", bus_a.phase_data, 16'h0455);
      check1("t16_done",  bus_a.frame_done, 1'b1);
      check1("t16_ferr",  bus_a.frame_err,  1'b0);

      // Plain timeout: frame_err exactly 16 cycles after the last byte
      cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'h02);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00);
         check1("to_wait_err", bus_a.frame_err, 1'b0);
      end
      check1("to_wait_busy", bus_a.busy, 1'b1);
      cyc(0, 8'h00);
      check1("to_err",  bus_a.frame_err,  1'b1);
      check1("to_done", bus_a.frame_done, 1'b0);
      check1("to_busy", bus_a.busy,       1'b0);
      cyc(0, 8'h00);
      check1("to_err_pulse", bus_a.frame_err, 1'b0);

      // Reset mid-frame
      en0   = n_en;
      done0 = n_done;
      err0  = n_err;
      cyc(1, 8'hA5); cyc(1, 8'h02); cyc(1, 8'h03);
      @(negedge clk);
      rx_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check16("mrst_data", bus_a.phase_data, 16'h0000);
      check1("mrst_en",    bus_a.phase_en,   1'b0);
      check1("mrst_busy",  bus_a.busy,       1'b0);
      rst      = 1'b0;
      rx_valid = 1'b1;
      rx_byte  = 8'h44;
      cyc(0, 8'h00);
      cyc(0, 8'h00);
      check1("mrst_idle", bus_a.busy, 1'b0);
      check_int("mrst_no_en",   n_en,   en0);
      check_int("mrst_no_done", n_done, done0);
      check_int("mrst_no_err",  n_err,  err0);

      // Noise, then sync byte used as channel/phase data (NUM_CHANNELS=64)
      cyc(1, 8'h00); cyc(1, 8'h12);
      check1("noise_busy", bus_a.busy, 1'b0);
      cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'hA5); cyc(1, 8'hA5);
      cyc(0, 8'h00);
      check1("sync64_en",   bus_a.phase_en,   1'b0);
      check1("sync64_err",  bus_a.frame_err,  1'b1);
      check1("sync64_done", bus_a.frame_done, 1'b0);

      // Same stream into the NUM_CHANNELS=255 instance
      sel_b = 1'b1;
      cyc(1, 8'h00); cyc(1, 8'h12);
      cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'hA5); cyc(1, 8'hA5);
      cyc(0, 8'h00);
      check1("sync255_en",    bus_b.phase_en,   1'b1);
      check16("sync255_data", bus_b.phase_data, 16'hA5A5);
      check1("sync255_done",  bus_b.frame_done, 1'b1);
      check1("sync255_err",   bus_b.frame_err,  1'b0);
      sel_b = 1'b0;

      // Pulse totals for dut_a across the whole run
      cyc(0, 8'h00);
      cyc(0, 8'h00);
      check_int("total_en",   n_en,   6);
      check_int("total_done", n_done, 3);
      check_int("total_err",  n_err,  4);
      check_int("total_both", n_both, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
